// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Purpose  : 512 x 8 byte-addressable data memory, big-endian byte/half/word
//            access with registered data_out and mfc acknowledge.
//            Optional macro RAM_ALIGN_CHECK_EN adds the misaligned flag port.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] data_out,
    output logic              mfc,
`ifdef RAM_ALIGN_CHECK_EN
    output logic              misaligned,
`endif
    input  logic              enable,
    input  logic              read_write,
    input  logic [1:0]        data_length,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in
);

    localparam int        c_DEPTH    = 2 ** ADDR_W;
    localparam logic [1:0] c_LEN_BYTE = 2'b00;
    localparam logic [1:0] c_LEN_HALF = 2'b01;
    localparam logic [1:0] c_LEN_WORD = 2'b10;

    logic [7:0] memory [c_DEPTH];

    logic [ADDR_W-1:0] w_addr    [4];
    logic [7:0]        w_rd_byte [4];
    logic [7:0]        w_wr_byte [4];
    logic [3:0]        w_wr_en;
    logic [DATA_W-1:0] w_rdata;
    logic              w_misaligned;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              mfc_q, mfc_d;

    // Lane k always addresses byte k of the access; the adder wraps modulo depth.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_addr[k]    = address + ADDR_W'(k);
            w_rd_byte[k] = memory[w_addr[k]];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (data_length)
            c_LEN_BYTE: w_rdata = {24'b0, w_rd_byte[0]};
            c_LEN_HALF: w_rdata = {16'b0, w_rd_byte[0], w_rd_byte[1]};
            c_LEN_WORD: w_rdata = {w_rd_byte[0], w_rd_byte[1], w_rd_byte[2], w_rd_byte[3]};
            default:    w_rdata = '0;
        endcase
    end

    // Write data is right-justified, so lane 0 takes the most significant used byte.
    always_comb begin
        w_wr_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_wr_byte[k] = 8'h00;
        end
        case (data_length)
            c_LEN_BYTE: begin
                w_wr_en      = 4'b0001;
                w_wr_byte[0] = data_in[7:0];
            end
            c_LEN_HALF: begin
                w_wr_en      = 4'b0011;
                w_wr_byte[0] = data_in[15:8];
                w_wr_byte[1] = data_in[7:0];
            end
            c_LEN_WORD: begin
                w_wr_en      = 4'b1111;
                w_wr_byte[0] = data_in[31:24];
                w_wr_byte[1] = data_in[23:16];
                w_wr_byte[2] = data_in[15:8];
                w_wr_byte[3] = data_in[7:0];
            end
            default: w_wr_en = 4'b0000;
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign w_misaligned = ((data_length == c_LEN_HALF) && address[0]) ||
                          ((data_length == c_LEN_WORD) && (address[1:0] != 2'b00));
    assign misaligned_d = enable && w_misaligned;
    assign misaligned   = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && enable && !read_write && !w_misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_en[k]) begin
                    memory[w_addr[k]] <= w_wr_byte[k];
                end
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        mfc_d      = enable;
        if (enable && read_write) begin
            data_out_d = w_misaligned ? '0 : w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            mfc_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            mfc_q      <= mfc_d;
        end
    end

    assign data_out = data_out_q;
    assign mfc      = mfc_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram
// Purpose  : Randomized scoreboard bench for data_ram against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        read_write;
    logic [1:0]  data_length;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc;
`ifdef RAM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    data_ram #(.ADDR_W(9), .DATA_W(32)) ram (
        .clk         (clk),
        .reset       (reset),
        .data_out    (data_out),
        .mfc         (mfc),
`ifdef RAM_ALIGN_CHECK_EN
        .misaligned  (misaligned),
`endif
        .enable      (enable),
        .read_write  (read_write),
        .data_length (data_length),
        .address     (address),
        .data_in     (data_in)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mdl_mem [DEPTH];
    logic [31:0] mdl_dout;
    int          n_vec = 0;
    int          n_err = 0;
    logic        en_seen = 1'b0;
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        case (len)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_mis(input logic [1:0] len, input logic [8:0] addr);
`ifdef RAM_ALIGN_CHECK_EN
        return (len == 2'b01 && (int'(addr) % 2) != 0) || (len == 2'b10 && (int'(addr) % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Model updates at issue time; one expected ack is queued per enabled cycle.
    task automatic access(input logic rw, input logic [1:0] len, input logic [8:0] addr,
                          input logic [31:0] din, input int hold);
        int          n;
        logic        mis;
        logic [31:0] v;
        exp_t        e;
        n   = nbytes(len);
        mis = model_mis(len, addr);
        v   = 32'h0;
        if (rw) begin
            if (!mis) begin
                for (int k = 0; k < n; k++) begin
                    v = (v << 8) | 32'(mdl_mem[(int'(addr) + k) % DEPTH]);
                end
            end
            mdl_dout = v;
        end else if (!mis) begin
            for (int k = 0; k < n; k++) begin
                mdl_mem[(int'(addr) + k) % DEPTH] = 8'(din >> (8 * (n - 1 - k)));
            end
        end
        e.data = mdl_dout;
        e.mis  = mis;
        for (int h = 0; h < hold; h++) begin
            exp_q.push_back(e);
        end
        read_write  = rw;
        data_length = len;
        address     = addr;
        data_in     = din;
        enable      = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        enable      = 1'b0;
        read_write  = $urandom_range(0, 1);
        data_length = 2'($urandom);
        address     = 9'($urandom);
        data_in     = $urandom;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) en_seen <= enable && !reset;

    always @(negedge clk) begin
        if (mon_on) begin
            check("mfc", {31'b0, mfc}, {31'b0, en_seen});
            if (mfc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got mfc=1 expected no pending access at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out", data_out, mon_e.data);
`ifdef RAM_ALIGN_CHECK_EN
                    check("misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
`endif
                end
            end
`ifdef RAM_ALIGN_CHECK_EN
            else begin
                check("misaligned_idle", {31'b0, misaligned}, 32'h0);
            end
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]     = (i < 16) ? 8'(i) : 8'($urandom);
            ram.memory[i]  = mdl_mem[i];
        end
        mdl_dout    = 32'h0;
        reset       = 1'b1;
        enable      = 1'b1;
        read_write  = 1'b0;
        data_length = 2'b10;
        address     = 9'd0;
        data_in     = 32'hFFFF_FFFF;

        // Reset overrides a concurrent word write.
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        check("reset_dout_1", data_out, 32'h0);
        @(posedge clk);
        #1;
        check("reset_dout_2", data_out, 32'h0);
        reset  = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("reset_mem", {24'b0, ram.memory[k]}, 32'(k));
        end

        for (int i = 0; i < 16; i++) begin
            access(1'b1, 2'b00, 9'(i), $urandom, 1);
            check("preload_byte", data_out, 32'(i));
        end

        access(1'b0, 2'b00, 9'd0, 32'h0000_000A, 1);
        access(1'b0, 2'b01, 9'd2, 32'h0000_0400, 1);
        access(1'b0, 2'b01, 9'd4, 32'h0000_0800, 1);
        access(1'b0, 2'b10, 9'd8, 32'h0010_0000, 1);
        access(1'b1, 2'b00, 9'd0, 32'h0, 1);
        check("rd_byte0", data_out, 32'h0000_000A);
        access(1'b1, 2'b01, 9'd2, 32'h0, 1);
        check("rd_half2", data_out, 32'h0000_0400);
        access(1'b1, 2'b01, 9'd4, 32'h0, 1);
        check("rd_half4", data_out, 32'h0000_0800);
        access(1'b1, 2'b10, 9'd8, 32'h0, 1);
        check("rd_word8", data_out, 32'h0010_0000);
        check("mem2", {24'b0, ram.memory[2]}, 32'h04);
        check("mem3", {24'b0, ram.memory[3]}, 32'h00);
        check("mem9", {24'b0, ram.memory[9]}, 32'h10);
        access(1'b1, 2'b10, 9'd0, 32'h0, 1);
        check("rd_word0_be", data_out, 32'h0A01_0400);

`ifndef RAM_ALIGN_CHECK_EN
        access(1'b0, 2'b10, 9'd510, 32'h1122_3344, 1);
        check("wrap_mem510", {24'b0, ram.memory[510]}, 32'h11);
        check("wrap_mem511", {24'b0, ram.memory[511]}, 32'h22);
        check("wrap_mem0",   {24'b0, ram.memory[0]},   32'h33);
        check("wrap_mem1",   {24'b0, ram.memory[1]},   32'h44);
        access(1'b1, 2'b10, 9'd510, 32'h0, 1);
        check("wrap_rd", data_out, 32'h1122_3344);
`endif

        access(1'b0, 2'b11, 9'h20, 32'hDEAD_BEEF, 1);
        for (int k = 0; k < 4; k++) begin
            check("reserved_wr_mem", {24'b0, ram.memory[32 + k]}, {24'b0, mdl_mem[32 + k]});
        end
        access(1'b1, 2'b11, 9'h20, 32'h0, 1);
        check("reserved_rd", data_out, 32'h0);

`ifdef RAM_ALIGN_CHECK_EN
        access(1'b1, 2'b10, 9'd8, 32'h0, 1);
        access(1'b1, 2'b01, 9'd3, 32'h0, 1);
        check("misaligned_rd", data_out, 32'h0);
`endif

        access(1'b1, 2'b10, 9'd4, 32'h0, 3);
        access(1'b0, 2'b10, 9'd100, $urandom, 2);
        access(1'b1, 2'b10, 9'd100, 32'h0, 1);

        repeat (300) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)),
                   $urandom, $urandom_range(1, 2));
        end

        // Reset landing on an enabled read aborts it and clears data_out.
        access(1'b0, 2'b10, 9'h40, 32'hCAFE_F00D, 1);
        access(1'b1, 2'b10, 9'h40, 32'h0, 1);
        check("pre_abort_rd", data_out, 32'hCAFE_F00D);
        read_write  = 1'b1;
        data_length = 2'b10;
        address     = 9'h40;
        enable      = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        enable   = 1'b0;
        mdl_dout = 32'h0;
        check("abort_dout", data_out, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            check("final_mem", {24'b0, ram.memory[i]}, {24'b0, mdl_mem[i]});
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("pending_acks", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_ram.md
Name: data_ram

Overview:
- Byte-addressable 512 x 8 data memory for the processor data path.
- Supports byte, halfword and word reads and writes, with big-endian byte ordering.
- Uses a single clock with a level-sensitive enable request.
- Asserts mfc (memory function complete) to acknowledge each access to the control unit.

Parameters:
- ADDR_W, 9, address width; memory depth is 2**ADDR_W bytes (512).
- DATA_W, 32, data bus width; fixed at 32, the only supported value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_out  output  32  read data, zero-extended, registered.
- mfc  output  1  access complete / acknowledge, registered.
- enable  input  1  access request, level-sensitive.
- read_write  input  1  1 = read, 0 = write.
- data_length  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- address  input  9  byte address of the most-significant byte of the access.
- data_in  input  32  write data, right-justified.

Behaviour:
- Storage is an array named memory, 512 entries of 8 bits. It is not cleared by reset, so benches may preload it hierarchically (ram.memory[i]).
- Reset (sampled on a clk rising edge with reset=1): data_out <= 0, mfc <= 0. Reset overrides any access; no memory write occurs in that cycle. Reset asserted mid-access aborts the access with mfc=0.
- Access: on each rising edge with reset=0 and enable=1, the addressed operation executes and mfc <= 1 at that edge (one-cycle latency from enable sampled high).
- Holding enable high repeats the access every cycle with mfc kept high. Repeated writes are idempotent; repeated reads refresh data_out.
- On a rising edge with enable=0: mfc <= 0, data_out holds its last value, memory is unchanged.
- Byte address map: byte k of an access is memory[(address + k) mod 512]. There is no alignment requirement; the address wraps modulo 512.
- Read, byte: data_out = {24'b0, mem[a]}.
- Read, halfword: data_out = {16'b0, mem[a], mem[a+1]}.
- Read, word: data_out = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Write, byte: mem[a] = data_in[7:0].
- Write, halfword: mem[a] = data_in[15:8], mem[a+1] = data_in[7:0].
- Write, word: mem[a..a+3] = data_in[31:24], [23:16], [15:8], [7:0].
- On a write, data_out holds its previous value.
- data_length = 11 is reserved: a write changes no memory, a read returns data_out = 0, and mfc is still asserted so the requester never hangs.
- read_write, data_length, address and data_in are sampled only on edges where enable=1; they may change freely at other times.
- A read following a write to the same location on the next enabled edge returns the new data. There is no internal forwarding requirement beyond sequential edges.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined: adds output port misaligned (1 bit, reset 0). A halfword with address[0]=1, or a word with address[1:0]!=0, is misaligned. For a misaligned access:
  - write: suppressed, memory unchanged;
  - read: returns data_out = 0;
  - flags: mfc=1 and misaligned=1 in the same cycle; misaligned clears on the next edge with enable=0 or an aligned access.
- Undefined: no misaligned port; unaligned accesses proceed byte-wise with address wrap as above.

Test Plan:
- Reset: assert reset for 2 cycles with enable=1, write word 0xFFFFFFFF at address 0 -> data_out=0, mfc=0, mem[0..3] unchanged after reset.
- Backdoor preload memory[i]=i for i=0..15; read byte at address 0..15 one per enable pulse -> data_out=0x0000000i, mfc high exactly one cycle after each enable-high edge and low after enable drops.
- Write byte 0x0A at address 0, halfword 0x00000400 at address 2, halfword 0x00000800 at address 4, word 0x00100000 at address 8. Read back with the same lengths -> 0x0000000A, 0x00000400, 0x00000800, 0x00100000. Also check mem[2]=0x04, mem[3]=0x00, mem[9]=0x10.
- Word read at address 0 after the writes above (mem[1]=0x01 from the preload) -> 0x0A010400 (big-endian concatenation).
- Wrap: write word 0x11223344 at address 510 (macro undefined) -> mem[510]=0x11, mem[511]=0x22, mem[0]=0x33, mem[1]=0x44. Word read at 510 -> 0x11223344.
- data_length=11 write of 0xDEADBEEF at 0x20 -> memory unchanged, mfc=1. A subsequent reserved read -> data_out=0. With RAM_ALIGN_CHECK_EN defined, a halfword read at address 3 -> misaligned=1, mfc=1, data_out=0.
